// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for EX-stage ALU control decode and the multiply/divide sequencer.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    CTL_AND  = 4'b0000,
    CTL_OR   = 4'b0001,
    CTL_ADD  = 4'b0010,
    CTL_SUB  = 4'b0110,
    CTL_SLT  = 4'b0111,
    CTL_SLTU = 4'b1000,
    CTL_XOR  = 4'b1001,
    CTL_SLL  = 4'b1010,
    CTL_SRL  = 4'b1011,
    CTL_NOR  = 4'b1100,
    CTL_SRA  = 4'b1101,
    CTL_MFHI = 4'b1110,
    CTL_MFLO = 4'b1111
  } alu_ctl_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_ctrl_mdu_md_seq.sv
// Iterative shift-add multiply / restoring divide on operand magnitudes, sign-fixed at the end.
// Latency: hi/lo written WIDTH+1 edges after start; busy for WIDTH+1 cycles.
// Backpressure: start is ignored unless IDLE; kill aborts without touching hi/lo.
module md_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_uns,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  md_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, sh, opb;
  logic             is_div, neg_q, neg_r, b_zero;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum, div_sh, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign a_neg = ~op_uns & a[WIDTH-1];
  assign b_neg = ~op_uns & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc is the running high half (mult) or partial remainder (div); sh holds multiplier/quotient bits
  assign add_sum  = {1'b0, acc} + (sh[0] ? {1'b0, opb} : '0);
  assign div_sh   = {acc, sh[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};
  assign div_ge   = ~div_diff[WIDTH];

  assign prod     = {acc, sh};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -sh : sh;
  assign r_fix    = neg_r ? -acc : acc;

  assign busy = (state != MD_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start && !kill) state_nxt = MD_RUN;
      MD_RUN: begin
        if (kill)                      state_nxt = MD_IDLE;
        else if (cnt == CNT_W'(1))     state_nxt = MD_FIX;
      end
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      sh     <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: if (start && !kill) begin
          cnt    <= CNT_W'(WIDTH);
          acc    <= '0;
          sh     <= a_mag;
          opb    <= b_mag;
          is_div <= op_div;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          b_zero <= (b == '0);
          dz     <= 1'b0;
        end
        MD_RUN: if (!kill) begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            acc <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            sh  <= {sh[WIDTH-2:0], div_ge};
          end else begin
            acc <= add_sum[WIDTH:1];
            sh  <= {add_sum[0], sh[WIDTH-1:1]};
          end
        end
        MD_FIX: if (!kill) begin
          done <= 1'b1;
          if (is_div) begin
            // zero divisor leaves the dividend magnitude in acc, so r_fix restores the dividend
            hi <= r_fix;
            lo <= b_zero ? '1 : q_fix;
            dz <= b_zero;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decode with registered 4-bit control and an optional iterative MDU.
// Latency: alu_control/illegal one cycle after accept; MDU results WIDTH+1 edges after accept.
// Backpressure: stall_out holds MDU-class instructions while the MDU is busy.
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ENABLE_MDU = 1,
  parameter int CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             kill,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic             stall_out,
  output logic             md_busy,
  output logic             md_done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam bit MDU_ON = (ENABLE_MDU != 0);

  alu_ctl_e dec_ctrl;
  logic     dec_ill, md_fn, md_start_fn;
  logic     accept, md_start;

  always_comb begin
    dec_ctrl    = CTL_ADD;
    dec_ill     = 1'b0;
    md_fn       = 1'b0;
    md_start_fn = 1'b0;
    case (alu_op)
      ALUOP_ADD: dec_ctrl = CTL_ADD;
      ALUOP_SUB: dec_ctrl = CTL_SUB;
      ALUOP_SLT: dec_ctrl = CTL_SLT;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: dec_ctrl = CTL_ADD;
          FN_SUB, FN_SUBU: dec_ctrl = CTL_SUB;
          FN_AND:          dec_ctrl = CTL_AND;
          FN_OR:           dec_ctrl = CTL_OR;
          FN_XOR:          dec_ctrl = CTL_XOR;
          FN_NOR:          dec_ctrl = CTL_NOR;
          FN_SLT:          dec_ctrl = CTL_SLT;
          FN_SLTU:         dec_ctrl = CTL_SLTU;
          FN_SLL:          dec_ctrl = CTL_SLL;
          FN_SRL:          dec_ctrl = CTL_SRL;
          FN_SRA:          dec_ctrl = CTL_SRA;
          FN_MFHI: begin
            if (MDU_ON) begin dec_ctrl = CTL_MFHI; md_fn = 1'b1; end
            else dec_ill = 1'b1;
          end
          FN_MFLO: begin
            if (MDU_ON) begin dec_ctrl = CTL_MFLO; md_fn = 1'b1; end
            else dec_ill = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            if (MDU_ON) begin md_fn = 1'b1; md_start_fn = 1'b1; end
            else dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ctrl = CTL_ADD;
    endcase
  end

  assign stall_out = valid_in & md_fn & md_busy;
  assign accept    = valid_in & ~stall_out;
  assign md_start  = accept & md_start_fn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_control <= CTL_ADD;
      illegal     <= 1'b0;
    end else if (accept) begin
      alu_control <= dec_ctrl;
      illegal     <= dec_ill;
    end
  end

  generate
    if (ENABLE_MDU != 0) begin : g_mdu
      // funct[1] selects divide, funct[0] selects unsigned within the mult/div group
      md_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op_div (funct[1]),
        .op_uns (funct[0]),
        .a      (src_a),
        .b      (src_b),
        .kill   (kill),
        .hi     (hi),
        .lo     (lo),
        .busy   (md_busy),
        .done   (md_done),
        .dz     (div_by_zero)
      );
    end else begin : g_no_mdu
      logic unused_mdu_in;
      assign unused_mdu_in = ^{src_a, src_b, kill, md_start};
      assign hi          = '0;
      assign lo          = '0;
      assign md_busy     = 1'b0;
      assign md_done     = 1'b0;
      assign div_by_zero = 1'b0;
    end
  endgenerate

endmodule
